data_cache_assoc: RTL and testbench
===================================

Name: data_cache_assoc

Overview:
Parametrised set-associative, write-back, write-allocate data cache for the ARM v4 pipelined core, sitting between the memory stage and the block-wide memory interface. It generalises the direct-mapped, read-fill cache. Additions over that cache:
- configurable associativity with per-set LRU replacement
- byte-enabled write hits
- dirty-block writeback
- a memready handshake toward memory
Hits complete in the same cycle; misses stall the pipeline until the block is resident.

Parameters:
blocksize, 4, words per block (power of 2, >=1)
lines, 256, sets per way (power of 2)
ways, 2, associativity (1 or 2)
tagbits, 30-$clog2(blocksize)-$clog2(lines), derived; not overridden

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
valid  input  1  memory-stage request valid
MemtoRegM  input  1  read request
MemWriteM  input  1  write request
a  input  32  byte address
wd  input  32  write data
byteen  input  4  byte enables for writes; bit i enables wd[8i+7:8i]
rd  output  32  read data (combinational on hit)
stall  output  1  pipeline stall
memread  output  1  block fill request
memwrite  output  1  block writeback request
memaddr  output  32  block-aligned memory address
memwd  output  blocksize*32  writeback block
memdata  input  blocksize*32  fill block
memready  input  1  memory completes current read/write this cycle

Behaviour:
- Address split: offset a[1+$clog2(blocksize):2] selects word; index a[next $clog2(lines) bits]; tag a[31:31-tagbits+1].
- Word order inside a block: word 0 in MSBs, i.e. word i = block[(blocksize-i)*32-1 -: 32]. The same order applies to memdata and memwd.
- Request: req = valid & (MemtoRegM | MemWriteM). hit = any way with valid & tag match; at most one way matches.
- stall = req & ~hit, or state != IDLE.
- Reset (async, low):
  - state=IDLE; all valid, dirty and LRU bits cleared.
  - memread=0, memwrite=0, stall=0 while reset is low. Data/tag arrays are not reset.
  - Reset mid-writeback or mid-fill abandons the transaction immediately. No partial update is made.
- FSM states:
  - IDLE: on req & hit, reads return rd combinationally with zero latency. A write hit updates the enabled bytes at the clock edge and sets dirty. LRU marks the hit way most-recent. On req & ~hit, pick victim = an invalid way (lowest index first), else the LRU way. Go to WRITEBACK if the victim is valid & dirty, else FILL.
  - WRITEBACK: memwrite=1; memaddr={victim tag, index, offset 0s}; memwd=victim block. Hold until memready, then go to FILL.
  - FILL: memread=1; memaddr={a[31:2+log2 blocksize], 0s}. On memready: write memdata to the victim way, set valid=1, dirty=0, tag=current tag; go to IDLE. The request now hits, and the write or read resolves in that IDLE cycle.
- memaddr = a & block mask in IDLE (don't-care). memread and memwrite are never high simultaneously.
- Requester holds a, wd, byteen, MemtoRegM, MemWriteM and valid stable while stall=1. Behaviour is undefined otherwise.
- ways=1: LRU logic absent; the victim is always way 0.
- valid=0: no state change, stall=0, no memory traffic. memready outside WRITEBACK/FILL is ignored.
- MemtoRegM & MemWriteM both set: treated as a write; rd still shows the pre-write word.

Decomposition:
- Package data_cache_pkg holds:
  - state enum {IDLE, WRITEBACK, FILL}
  - word-select and address-field helper functions, parametrised by blocksize/lines
- Sub-module data_cache_way: one way's tag/valid/dirty/data arrays. It has a combinational read port and a write port with a per-word, per-byte write mask. Instantiated ways times.
- The top holds the FSM, LRU bits, victim select and muxing.

Test Plan:
- Cold read miss: after reset, read a=0x00000040 → stall=1, memread=1, memaddr=0x00000040. Drive memready with memdata={0x11111111,0x22222222,0x33333333,0x44444444} → next cycle stall=0, rd=0x11111111. Then read 0x4C → rd=0x44444444 with no stall.
- Byte write hit: write a=0x44, wd=0xAABBCCDD, byteen=0011 → no stall, no memwrite. A following read of 0x44 returns 0x2222CCDD.
- LRU: fill 0x00000040 and 0x00010040 (same set 4). Read 0x40, then miss on 0x00020040 → way holding 0x00010040 replaced. A read of 0x40 still hits.
- Dirty eviction: after the byte write, touch 0x00010040 then miss 0x00020040 → memwrite=1, memaddr=0x00000040, memwd word 1=0x2222CCDD. After memready, memread=1 with memaddr=0x00020040.
- Reset mid-fill: drop reset while memread=1 → memread=0, stall=0 immediately. After release, a read of the same address misses again.
- Idle: valid=0 with MemtoRegM=1, random a → stall=0, memread=memwrite=0 for 10 cycles.

Source files
------------

// File: rtl/data_cache_pkg.sv
// Shared types and address/word helpers for the set-associative data cache.
package data_cache_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } state_t;

    // Word 0 lives in the most significant bits of a block.
    function automatic int unsigned word_lsb(input int unsigned bsize, input int unsigned word);
        return (bsize - 1 - word) * 32;
    endfunction

    function automatic logic [31:0] addr_field(input logic [31:0] addr,
                                               input int unsigned lsb,
                                               input int unsigned nbits);
        return (addr >> lsb) & ((32'd1 << nbits) - 32'd1);
    endfunction

endpackage

// File: rtl/data_cache_way.sv
// One cache way: tag/valid/dirty/data arrays with a combinational read port
// and a byte-masked write port sharing the same set index.
module data_cache_way
    import data_cache_pkg::*;
#(
    parameter int blocksize = 4,
    parameter int lines     = 256,
    parameter int tagbits   = 20,
    localparam int IB       = $clog2(lines)
) (
    input  logic                      clk,
    input  logic                      rst_ni,
    input  logic [IB-1:0]             idx_i,
    input  logic [blocksize*4-1:0]    byte_we_i,
    input  logic [blocksize*32-1:0]   wdata_i,
    input  logic                      fill_we_i,
    input  logic [tagbits-1:0]        tag_i,
    input  logic                      dirty_set_i,
    output logic                      valid_o,
    output logic                      dirty_o,
    output logic [tagbits-1:0]        tag_o,
    output logic [blocksize*32-1:0]   data_o
);

    logic [blocksize*32-1:0] data_q [lines];
    logic [tagbits-1:0]      tag_q  [lines];
    logic [lines-1:0]        valid_q;
    logic [lines-1:0]        dirty_q;

    assign valid_o = valid_q[idx_i];
    assign dirty_o = dirty_q[idx_i];
    assign tag_o   = tag_q[idx_i];
    assign data_o  = data_q[idx_i];

    // Payload arrays carry no reset; only the state bits are cleared.
    always_ff @(posedge clk) begin
        for (int k = 0; k < blocksize * 4; k++) begin
            if (byte_we_i[k]) data_q[idx_i][8*k +: 8] <= wdata_i[8*k +: 8];
        end
        if (fill_we_i) tag_q[idx_i] <= tag_i;
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_we_i) begin
            valid_q[idx_i] <= 1'b1;
            dirty_q[idx_i] <= 1'b0;
        end else if (dirty_set_i) begin
            dirty_q[idx_i] <= 1'b1;
        end
    end

endmodule

// File: rtl/data_cache_assoc.sv
// Set-associative write-back/write-allocate data cache: hit muxing, LRU,
// victim selection and the IDLE/WRITEBACK/FILL miss sequencer.
module data_cache_assoc
    import data_cache_pkg::*;
#(
    parameter int blocksize = 4,
    parameter int lines     = 256,
    parameter int ways      = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    valid,
    input  logic                    MemtoRegM,
    input  logic                    MemWriteM,
    input  logic [31:0]             a,
    input  logic [31:0]             wd,
    input  logic [3:0]              byteen,
    output logic [31:0]             rd,
    output logic                    stall,
    output logic                    memread,
    output logic                    memwrite,
    output logic [31:0]             memaddr,
    output logic [blocksize*32-1:0] memwd,
    input  logic [blocksize*32-1:0] memdata,
    input  logic                    memready
);

    localparam int OB      = $clog2(blocksize);
    localparam int IB      = $clog2(lines);
    localparam int tagbits = 30 - OB - IB;

    state_t state_q, state_d;
    logic   victim_q, victim_d;

    logic [IB-1:0]           idx;
    logic [31:0]             off;
    logic [tagbits-1:0]      tag_cur;
    logic                    req, hit, hit_way, vsel, fill, wr_hit;
    logic [ways-1:0]         hit_vec, w_valid, w_dirty, w_fill, w_dset;
    logic [tagbits-1:0]      w_tag  [ways];
    logic [blocksize*32-1:0] w_data [ways];
    logic [blocksize*4-1:0]  w_bwe  [ways];
    logic [blocksize*4-1:0]  wmask;
    logic [blocksize*32-1:0] wdata, sel_block;

    assign idx     = IB'(addr_field(a, 2 + OB, IB));
    assign off     = addr_field(a, 2, OB);
    assign tag_cur = a[31 -: tagbits];
    assign req     = valid & (MemtoRegM | MemWriteM);
    assign hit     = |hit_vec;

    assign sel_block = w_data[hit_way];
    assign rd        = sel_block[word_lsb(blocksize, off) +: 32];
    assign memwd     = w_data[victim_q];
    assign wdata     = fill ? memdata : {blocksize{wd}};

    for (genvar w = 0; w < ways; w++) begin : g_way
        data_cache_way #(.blocksize(blocksize), .lines(lines), .tagbits(tagbits)) u_way (
            .clk         (clk),
            .rst_ni      (reset),
            .idx_i       (idx),
            .byte_we_i   (w_bwe[w]),
            .wdata_i     (wdata),
            .fill_we_i   (w_fill[w]),
            .tag_i       (tag_cur),
            .dirty_set_i (w_dset[w]),
            .valid_o     (w_valid[w]),
            .dirty_o     (w_dirty[w]),
            .tag_o       (w_tag[w]),
            .data_o      (w_data[w])
        );
        assign hit_vec[w] = w_valid[w] & (w_tag[w] == tag_cur);
    end

    if (ways > 1) begin : g_lru
        // lru_q[set] names the least recently used way of that set.
        logic [lines-1:0] lru_q;
        always_ff @(posedge clk or negedge reset) begin
            if (!reset)                              lru_q      <= '0;
            else if (state_q == IDLE && req && hit)  lru_q[idx] <= ~hit_way;
            else if (fill)                           lru_q[idx] <= ~victim_q;
        end
        assign hit_way = hit_vec[1];
        assign vsel    = !w_valid[0] ? 1'b0 : (!w_valid[1] ? 1'b1 : lru_q[idx]);
    end else begin : g_no_lru
        assign hit_way = 1'b0;
        assign vsel    = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            victim_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        victim_d = victim_q;
        memread  = 1'b0;
        memwrite = 1'b0;
        memaddr  = a & ~(32'(blocksize * 4) - 32'd1);
        fill     = 1'b0;
        wr_hit   = 1'b0;
        unique case (state_q)
            IDLE: begin
                wr_hit = req & hit & MemWriteM;
                if (req && !hit) begin
                    victim_d = vsel;
                    state_d  = (w_valid[vsel] && w_dirty[vsel]) ? WRITEBACK : FILL;
                end
            end
            WRITEBACK: begin
                memwrite = 1'b1;
                memaddr  = {w_tag[victim_q], idx, {(2 + OB){1'b0}}};
                if (memready) state_d = FILL;
            end
            FILL: begin
                memread = 1'b1;
                if (memready) begin
                    fill    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Held low during reset even though a request may be presented.
    assign stall = reset & ((req & ~hit) | (state_q != IDLE));

    always_comb begin
        wmask = '0;
        wmask[(blocksize - 1 - int'(off)) * 4 +: 4] = byteen;
        for (int w = 0; w < ways; w++) begin
            w_bwe[w]  = '0;
            w_fill[w] = 1'b0;
            w_dset[w] = 1'b0;
            if (fill && int'(victim_q) == w) begin
                w_bwe[w]  = '1;
                w_fill[w] = 1'b1;
            end
            if (wr_hit && hit_vec[w]) begin
                w_bwe[w]  = wmask;
                w_dset[w] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_data_cache_assoc.sv
// Directed bench for data_cache_assoc: fills, byte writes, LRU, dirty eviction, reset.
module tb_data_cache_assoc;

    logic         clk = 1'b0;
    logic         reset;
    logic         valid, MemtoRegM, MemWriteM;
    logic [31:0]  a, wd;
    logic [3:0]   byteen;
    logic [31:0]  rd;
    logic         stall, memread, memwrite;
    logic [31:0]  memaddr;
    logic [127:0] memwd, memdata;
    logic         memready;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] BLK_A = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    localparam logic [127:0] BLK_B = {32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};
    localparam logic [127:0] BLK_C = {32'h99999999, 32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC};

    always #5 clk = ~clk;

    data_cache_assoc dut (
        .clk(clk), .reset(reset), .valid(valid), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
        .a(a), .wd(wd), .byteen(byteen), .rd(rd), .stall(stall), .memread(memread),
        .memwrite(memwrite), .memaddr(memaddr), .memwd(memwd), .memdata(memdata),
        .memready(memready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_req(input logic [31:0] addr);
        valid = 1'b1; MemtoRegM = 1'b1; MemWriteM = 1'b0; a = addr;
    endtask

    task automatic test_reset();
        reset = 1'b0; memready = 1'b0; memdata = '0; wd = '0; byteen = '0;
        rd_req(32'h40);
        #2;
        checks++;
        if (stall !== 1'b0 || memread !== 1'b0 || memwrite !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got stall=%b rdreq=%b wrreq=%b exp 0 0 0", stall, memread, memwrite);
        end
        valid = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_cold_miss();
        rd_req(32'h40);
        #1;
        checks++;
        if (stall !== 1'b1 || memread !== 1'b0) begin
            errors++;
            $display("FAIL cold_miss_idle got stall=%b rdreq=%b exp 1 0", stall, memread);
        end
        tick();
        checks++;
        if (memread !== 1'b1 || memwrite !== 1'b0 || memaddr !== 32'h40 || stall !== 1'b1) begin
            errors++;
            $display("FAIL cold_miss_fill got rdreq=%b wrreq=%b addr=%h stall=%b exp 1 0 00000040 1",
                     memread, memwrite, memaddr, stall);
        end
        memready = 1'b1; memdata = BLK_A;
        tick();
        memready = 1'b0;
        checks++;
        if (stall !== 1'b0 || rd !== 32'h11111111) begin
            errors++;
            $display("FAIL cold_miss_done got stall=%b rd=%h exp 0 11111111", stall, rd);
        end
        a = 32'h4C;
        #1;
        checks++;
        if (stall !== 1'b0 || rd !== 32'h44444444) begin
            errors++;
            $display("FAIL read_word3 got stall=%b rd=%h exp 0 44444444", stall, rd);
        end
        tick();
    endtask

    task automatic test_byte_write();
        valid = 1'b1; MemtoRegM = 1'b0; MemWriteM = 1'b1; a = 32'h44;
        wd = 32'hAABBCCDD; byteen = 4'b0011;
        #1;
        checks++;
        if (stall !== 1'b0 || memwrite !== 1'b0 || memread !== 1'b0) begin
            errors++;
            $display("FAIL byte_write_hit got stall=%b wrreq=%b rdreq=%b exp 0 0 0", stall, memwrite, memread);
        end
        tick();
        rd_req(32'h44);
        #1;
        checks++;
        if (stall !== 1'b0 || rd !== 32'h2222CCDD) begin
            errors++;
            $display("FAIL byte_write_readback got stall=%b rd=%h exp 0 2222ccdd", stall, rd);
        end
        tick();
    endtask

    task automatic test_lru();
        rd_req(32'h00010040);
        tick();
        checks++;
        if (memread !== 1'b1 || memwrite !== 1'b0 || memaddr !== 32'h00010040) begin
            errors++;
            $display("FAIL lru_second_fill got rdreq=%b wrreq=%b addr=%h exp 1 0 00010040", memread, memwrite, memaddr);
        end
        memready = 1'b1; memdata = BLK_B;
        tick();
        memready = 1'b0;
        checks++;
        if (stall !== 1'b0 || rd !== 32'h55555555) begin
            errors++;
            $display("FAIL lru_second_hit got stall=%b rd=%h exp 0 55555555", stall, rd);
        end
        rd_req(32'h40);
        tick();
        rd_req(32'h00020040);
        tick();
        checks++;
        if (memwrite !== 1'b0 || memread !== 1'b1 || memaddr !== 32'h00020040) begin
            errors++;
            $display("FAIL lru_clean_victim got wrreq=%b rdreq=%b addr=%h exp 0 1 00020040", memwrite, memread, memaddr);
        end
        memready = 1'b1; memdata = BLK_C;
        tick();
        memready = 1'b0;
        checks++;
        if (stall !== 1'b0 || rd !== 32'h99999999) begin
            errors++;
            $display("FAIL lru_third_hit got stall=%b rd=%h exp 0 99999999", stall, rd);
        end
        tick();
        rd_req(32'h44);
        #1;
        checks++;
        if (stall !== 1'b0 || rd !== 32'h2222CCDD) begin
            errors++;
            $display("FAIL lru_mru_kept got stall=%b rd=%h exp 0 2222ccdd", stall, rd);
        end
        tick();
        rd_req(32'h00010040);
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL lru_evicted got stall=%b exp 1", stall);
        end
        valid = 1'b0;
        tick();
    endtask

    task automatic test_dirty_evict();
        rd_req(32'h00020040);
        tick();
        rd_req(32'h00010040);
        tick();
        checks++;
        if (memwrite !== 1'b1 || memread !== 1'b0 || memaddr !== 32'h40 || stall !== 1'b1) begin
            errors++;
            $display("FAIL wb_start got wrreq=%b rdreq=%b addr=%h stall=%b exp 1 0 00000040 1",
                     memwrite, memread, memaddr, stall);
        end
        checks++;
        if (memwd[95:64] !== 32'h2222CCDD || memwd[127:96] !== 32'h11111111) begin
            errors++;
            $display("FAIL wb_data got w0=%h w1=%h exp 11111111 2222ccdd", memwd[127:96], memwd[95:64]);
        end
        tick();
        checks++;
        if (memwrite !== 1'b1 || memread !== 1'b0) begin
            errors++;
            $display("FAIL wb_hold got wrreq=%b rdreq=%b exp 1 0", memwrite, memread);
        end
        memready = 1'b1;
        tick();
        memready = 1'b0;
        checks++;
        if (memread !== 1'b1 || memwrite !== 1'b0 || memaddr !== 32'h00010040) begin
            errors++;
            $display("FAIL wb_then_fill got rdreq=%b wrreq=%b addr=%h exp 1 0 00010040", memread, memwrite, memaddr);
        end
        memready = 1'b1; memdata = BLK_B;
        tick();
        memready = 1'b0;
        checks++;
        if (stall !== 1'b0 || rd !== 32'h55555555) begin
            errors++;
            $display("FAIL wb_refill_hit got stall=%b rd=%h exp 0 55555555", stall, rd);
        end
        tick();
    endtask

    task automatic test_read_write_both();
        valid = 1'b1; MemtoRegM = 1'b1; MemWriteM = 1'b1; a = 32'h00020048;
        wd = 32'h12345678; byteen = 4'b1111;
        #1;
        checks++;
        if (stall !== 1'b0 || rd !== 32'hBBBBBBBB) begin
            errors++;
            $display("FAIL both_prewrite got stall=%b rd=%h exp 0 bbbbbbbb", stall, rd);
        end
        tick();
        rd_req(32'h00020048);
        #1;
        checks++;
        if (rd !== 32'h12345678) begin
            errors++;
            $display("FAIL both_written got rd=%h exp 12345678", rd);
        end
        tick();
    endtask

    task automatic test_reset_mid_fill();
        rd_req(32'h80);
        tick();
        checks++;
        if (memread !== 1'b1) begin
            errors++;
            $display("FAIL rst_fill_start got rdreq=%b exp 1", memread);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (memread !== 1'b0 || stall !== 1'b0 || memwrite !== 1'b0) begin
            errors++;
            $display("FAIL rst_abandon got rdreq=%b stall=%b wrreq=%b exp 0 0 0", memread, stall, memwrite);
        end
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b1 || memread !== 1'b0) begin
            errors++;
            $display("FAIL rst_remiss got stall=%b rdreq=%b exp 1 0", stall, memread);
        end
        tick();
        checks++;
        if (memread !== 1'b1 || memaddr !== 32'h80) begin
            errors++;
            $display("FAIL rst_refill got rdreq=%b addr=%h exp 1 00000080", memread, memaddr);
        end
        memready = 1'b1; memdata = BLK_A;
        tick();
        memready = 1'b0;
        checks++;
        if (stall !== 1'b0 || rd !== 32'h11111111) begin
            errors++;
            $display("FAIL rst_refill_hit got stall=%b rd=%h exp 0 11111111", stall, rd);
        end
        tick();
    endtask

    task automatic test_idle();
        valid = 1'b0; MemtoRegM = 1'b1; MemWriteM = 1'b0;
        for (int i = 0; i < 10; i++) begin
            a = $urandom;
            memready = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (stall !== 1'b0 || memread !== 1'b0 || memwrite !== 1'b0) begin
                errors++;
                $display("FAIL idle_cycle%0d got stall=%b rdreq=%b wrreq=%b exp 0 0 0", i, stall, memread, memwrite);
            end
            tick();
        end
        memready = 1'b0;
        rd_req(32'h40);
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL idle_no_state_change got stall=%b exp 1", stall);
        end
        valid = 1'b0;
    endtask

    initial begin
        valid = 1'b0; MemtoRegM = 1'b0; MemWriteM = 1'b0; a = '0;
        test_reset();
        test_cold_miss();
        test_byte_write();
        test_lru();
        test_dirty_evict();
        test_read_write_both();
        test_reset_mid_fill();
        test_idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
